// File: rtl/game_timer_bank.sv
// game_timer_bank -- CHANNELS independent interval timers on the 2 kHz clock.
//   Every channel has its own terminal count and its own one-shot or periodic
//   mode. Both are latched at start. The channels share only the global hold.
// Ports:
//   clk_2K, i_ResetNeg (async, active-high)  clock / reset
//   i_Hold                                    pauses every channel in RUN
//   i_Start/i_Clear/i_Periodic [CHANNELS]     per-channel control
//   i_Limit [CHANNELS*WIDTH]                  terminal count, ch i at [i*WIDTH +: WIDTH]
//   o_Count [CHANNELS*WIDTH]                  current count, same packing
//   o_Busy/o_Done [CHANNELS]                  levels: in RUN / in DONE
//   o_Tick/o_ClrAck [CHANNELS]                registered one-cycle pulses

module game_timer_ch #(
   parameter int WIDTH = 12
) (
   input  logic             clk_2K,
   input  logic             i_ResetNeg,
   input  logic             i_Hold,
   input  logic             i_Start,
   input  logic             i_Clear,
   input  logic             i_Periodic,
   input  logic [WIDTH-1:0] i_Limit,
   output logic [WIDTH-1:0] o_Count,
   output logic             o_Busy,
   output logic             o_Done,
   output logic             o_Tick,
   output logic             o_ClrAck
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] lim_q, lim_d;
   logic             per_q, per_d;
   logic             tick_q, tick_d;
   logic             ack_q, ack_d;

   always_ff @(posedge clk_2K or posedge i_ResetNeg) begin
      if (i_ResetNeg) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         lim_q   <= '0;
         per_q   <= 1'b0;
         tick_q  <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lim_q   <= lim_d;
         per_q   <= per_d;
         tick_q  <= tick_d;
         ack_q   <= ack_d;
      end
   end

   // Clear takes priority over start, start over hold, and hold over counting.
   // The terminal is compared before the increment, so the count never
   // passes the limit. This holds even for an all-ones limit, so no wrap occurs.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lim_d   = lim_q;
      per_d   = per_q;
      tick_d  = 1'b0;
      ack_d   = 1'b0;
      if (i_Clear) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         ack_d   = 1'b1;
      end else if (i_Start) begin
         state_d = S_RUN;
         cnt_d   = '0;
         lim_d   = i_Limit;
         per_d   = i_Periodic;
      end else if (state_q == S_RUN && !i_Hold) begin
         if (cnt_q == lim_q) begin
            tick_d = 1'b1;
            if (per_q) cnt_d = '0;
            else       state_d = S_DONE;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   assign o_Count  = cnt_q;
   assign o_Busy   = (state_q == S_RUN);
   assign o_Done   = (state_q == S_DONE);
   assign o_Tick   = tick_q;
   assign o_ClrAck = ack_q;
endmodule

module game_timer_bank #(
   parameter int WIDTH    = 12,
   parameter int CHANNELS = 4
) (
   input  logic                      clk_2K,
   input  logic                      i_ResetNeg,
   input  logic                      i_Hold,
   input  logic [CHANNELS-1:0]       i_Start,
   input  logic [CHANNELS-1:0]       i_Clear,
   input  logic [CHANNELS-1:0]       i_Periodic,
   input  logic [CHANNELS*WIDTH-1:0] i_Limit,
   output logic [CHANNELS*WIDTH-1:0] o_Count,
   output logic [CHANNELS-1:0]       o_Busy,
   output logic [CHANNELS-1:0]       o_Done,
   output logic [CHANNELS-1:0]       o_Tick,
   output logic [CHANNELS-1:0]       o_ClrAck
);
   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      game_timer_ch #(.WIDTH(WIDTH)) u_ch (
         .clk_2K     (clk_2K),
         .i_ResetNeg (i_ResetNeg),
         .i_Hold     (i_Hold),
         .i_Start    (i_Start[g]),
         .i_Clear    (i_Clear[g]),
         .i_Periodic (i_Periodic[g]),
         .i_Limit    (i_Limit[g*WIDTH +: WIDTH]),
         .o_Count    (o_Count[g*WIDTH +: WIDTH]),
         .o_Busy     (o_Busy[g]),
         .o_Done     (o_Done[g]),
         .o_Tick     (o_Tick[g]),
         .o_ClrAck   (o_ClrAck[g])
      );
   end
endmodule

// File: tb/tb_game_timer_bank.sv
// Bench for game_timer_bank. The reference model tracks, per channel, the
// number of counting edges that have elapsed since the last start. It derives
// count, busy, done and tick from that number arithmetically.
module tb_game_timer_bank;
   localparam int W  = 12;
   localparam int CH = 4;
   localparam int VW = CH*W + 4*CH;

   logic              clk_2K = 1'b0;
   logic              i_ResetNeg = 1'b0;
   logic              i_Hold = 1'b0;
   logic [CH-1:0]     i_Start = '0, i_Clear = '0, i_Periodic = '0;
   logic [CH*W-1:0]   i_Limit = '0;
   logic [CH*W-1:0]   o_Count;
   logic [CH-1:0]     o_Busy, o_Done, o_Tick, o_ClrAck;

   int n_tests = 0;
   int n_fail  = 0;

   // model: active = started and not cleared; e = counting edges since start
   bit m_act[CH];
   bit m_per[CH];
   bit m_tick[CH];
   bit m_ack[CH];
   int m_e[CH];
   int m_L[CH];

   game_timer_bank #(.WIDTH(W), .CHANNELS(CH)) dut (
      .clk_2K(clk_2K), .i_ResetNeg(i_ResetNeg), .i_Hold(i_Hold),
      .i_Start(i_Start), .i_Clear(i_Clear), .i_Periodic(i_Periodic),
      .i_Limit(i_Limit), .o_Count(o_Count), .o_Busy(o_Busy), .o_Done(o_Done),
      .o_Tick(o_Tick), .o_ClrAck(o_ClrAck));

   always #5 clk_2K = ~clk_2K;

   task automatic model_reset();
      for (int i = 0; i < CH; i++) begin
         m_act[i] = 0; m_per[i] = 0; m_tick[i] = 0; m_ack[i] = 0;
         m_e[i] = 0; m_L[i] = 0;
      end
   endtask

   task automatic model_edge();
      if (i_ResetNeg) begin model_reset(); return; end
      for (int i = 0; i < CH; i++) begin
         m_tick[i] = 0; m_ack[i] = 0;
         if (i_Clear[i]) begin
            m_act[i] = 0; m_e[i] = 0; m_ack[i] = 1;
         end else if (i_Start[i]) begin
            m_act[i] = 1; m_e[i] = 0;
            m_L[i] = int'(i_Limit[i*W +: W]); m_per[i] = i_Periodic[i];
         end else if (m_act[i] && !i_Hold && (m_per[i] || m_e[i] <= m_L[i])) begin
            m_e[i]++;
            if (m_e[i] % (m_L[i] + 1) == 0) m_tick[i] = 1;
         end
      end
   endtask

   function automatic logic [VW-1:0] expv();
      logic [CH*W-1:0] c;
      logic [CH-1:0]   b, d, t, a;
      int v;
      c = '0; b = '0; d = '0; t = '0; a = '0;
      for (int i = 0; i < CH; i++) begin
         v = 0;
         if (m_act[i]) v = m_per[i] ? m_e[i] % (m_L[i] + 1)
                                    : (m_e[i] > m_L[i] ? m_L[i] : m_e[i]);
         c[i*W +: W] = W'(v);
         b[i] = m_act[i] && (m_per[i] || m_e[i] <= m_L[i]);
         d[i] = m_act[i] && !m_per[i] && m_e[i] > m_L[i];
         t[i] = m_tick[i];
         a[i] = m_ack[i];
      end
      return {c, b, d, t, a};
   endfunction

   // One edge: the model consumes the same inputs as the DUT. The start and
   // clear pulses then drop.
   task automatic step();
      @(posedge clk_2K);
      model_edge();
      #1;
      i_Start = '0;
      i_Clear = '0;
   endtask

   task automatic set_lim(input int ch, input int val, input bit per);
      i_Limit[ch*W +: W] = W'(val);
      i_Periodic[ch] = per;
   endtask

   task automatic test_reset();
      i_ResetNeg = 1'b1;
      model_reset();
      #1;
      n_tests++;
      if ({o_Count, o_Busy, o_Done, o_Tick, o_ClrAck} !== expv()) begin
         n_fail++;
         $display("FAIL reset_state got=%h exp=%h", {o_Count, o_Busy, o_Done, o_Tick, o_ClrAck}, expv());
      end
      step();
      i_ResetNeg = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         n_tests++;
         if ({o_Count, o_Busy, o_Done, o_Tick, o_ClrAck} !== expv()) begin
            n_fail++;
            $display("FAIL reset_release cyc=%0d got=%h exp=%h", k, {o_Count, o_Busy, o_Done, o_Tick, o_ClrAck}, expv());
         end
      end
   endtask

   task automatic test_oneshot();
      set_lim(0, 5, 0);
      i_Start[0] = 1'b1;
      for (int k = 0; k <= 9; k++) begin
         step();
         n_tests++;
         if ({o_Count, o_Busy, o_Done, o_Tick, o_ClrAck} !== expv()) begin
            n_fail++;
            $display("FAIL oneshot cyc=%0d got=%h exp=%h", k, {o_Count, o_Busy, o_Done, o_Tick, o_ClrAck}, expv());
         end
         // fixed anchor: tick and done both appear after edge k+6
         if (k == 6) begin
            n_tests++;
            if ({o_Tick[0], o_Done[0], o_Count[W-1:0]} !== {1'b1, 1'b1, 12'd5}) begin
               n_fail++;
               $display("FAIL oneshot_terminal got=%b%b/%0d exp=11/5", o_Tick[0], o_Done[0], o_Count[W-1:0]);
            end
         end
      end
   endtask

   task automatic test_periodic();
      set_lim(1, 3, 1);
      i_Start[1] = 1'b1;
      for (int k = 0; k < 14; k++) begin
         step();
         set_lim(1, 9, 0);   // ignored until the next start
         n_tests++;
         if ({o_Count, o_Busy, o_Done, o_Tick, o_ClrAck} !== expv()) begin
            n_fail++;
            $display("FAIL periodic cyc=%0d got=%h exp=%h", k, {o_Count, o_Busy, o_Done, o_Tick, o_ClrAck}, expv());
         end
      end
   endtask

   task automatic test_hold();
      set_lim(2, 10, 0);
      set_lim(3, 2 + int'($urandom_range(0, 4)), 1);
      i_Start[3:2] = 2'b11;
      for (int k = 0; k < 20; k++) begin
         i_Hold = (k >= 5 && k < 9);
         if (k == 7) i_Start[1] = 1'b1;   // start is not blocked by hold
         if (k == 12) i_Clear[2] = 1'b1;  // clearing ch2 must leave ch3 alone
         step();
         n_tests++;
         if ({o_Count, o_Busy, o_Done, o_Tick, o_ClrAck} !== expv()) begin
            n_fail++;
            $display("FAIL hold cyc=%0d got=%h exp=%h", k, {o_Count, o_Busy, o_Done, o_Tick, o_ClrAck}, expv());
         end
      end
      i_Hold = 1'b0;
      set_lim(2, 10, 0);
      i_Start[2] = 1'b1;
      for (int k = 0; k < 18; k++) begin
         i_Hold = (k >= 3 && k < 7);
         step();
         n_tests++;
         if ({o_Count, o_Busy, o_Done, o_Tick, o_ClrAck} !== expv()) begin
            n_fail++;
            $display("FAIL hold_late cyc=%0d got=%h exp=%h", k, {o_Count, o_Busy, o_Done, o_Tick, o_ClrAck}, expv());
         end
      end
      i_Hold = 1'b0;
   endtask

   task automatic test_clear();
      set_lim(0, 7, 0);
      i_Start[0] = 1'b1;
      for (int k = 0; k < 8; k++) begin
         if (k == 3) begin i_Clear[0] = 1'b1; i_Start[0] = 1'b1; end
         if (k == 5) begin set_lim(0, 2, 0); i_Start[0] = 1'b1; end
         // edge 5 starts the channel, so edge 8 (k==8) would be the terminal
         step();
         n_tests++;
         if ({o_Count, o_Busy, o_Done, o_Tick, o_ClrAck} !== expv()) begin
            n_fail++;
            $display("FAIL clear cyc=%0d got=%h exp=%h", k, {o_Count, o_Busy, o_Done, o_Tick, o_ClrAck}, expv());
         end
      end
      i_Clear[0] = 1'b1;   // lands on the terminal edge
      for (int k = 0; k < 3; k++) begin
         step();
         n_tests++;
         if ({o_Count, o_Busy, o_Done, o_Tick, o_ClrAck} !== expv()) begin
            n_fail++;
            $display("FAIL clear_terminal cyc=%0d got=%h exp=%h", k, {o_Count, o_Busy, o_Done, o_Tick, o_ClrAck}, expv());
         end
         if (k == 0) begin
            n_tests++;
            if ({o_Tick[0], o_ClrAck[0]} !== 2'b01) begin
               n_fail++;
               $display("FAIL clear_wins tick/ack got=%b exp=01", {o_Tick[0], o_ClrAck[0]});
            end
         end
      end
   endtask

   task automatic test_limits();
      set_lim(1, 0, 1);
      set_lim(0, 4095, 0);
      i_Start[1:0] = 2'b11;
      for (int k = 0; k < 4100; k++) begin
         step();
         n_tests++;
         if ({o_Count, o_Busy, o_Done, o_Tick, o_ClrAck} !== expv()) begin
            n_fail++;
            $display("FAIL limits cyc=%0d got=%h exp=%h", k, {o_Count, o_Busy, o_Done, o_Tick, o_ClrAck}, expv());
         end
      end
      // async reset in mid-run, sampled before any further edge
      set_lim(2, 50, 1);
      i_Start[2] = 1'b1;
      step(); step(); step();
      #2;
      i_ResetNeg = 1'b1;
      model_reset();
      #1;
      n_tests++;
      if ({o_Count, o_Busy, o_Done, o_Tick, o_ClrAck} !== {VW{1'b0}}) begin
         n_fail++;
         $display("FAIL async_reset got=%h exp=0", {o_Count, o_Busy, o_Done, o_Tick, o_ClrAck});
      end
      step();
      i_ResetNeg = 1'b0;
   endtask

   task automatic test_random();
      for (int k = 0; k < 600; k++) begin
         i_Hold = ($urandom_range(0, 5) == 0);
         for (int i = 0; i < CH; i++) begin
            i_Start[i] = ($urandom_range(0, 14) == 0);
            i_Clear[i] = ($urandom_range(0, 29) == 0);
            set_lim(i, int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)));
         end
         step();
         n_tests++;
         if ({o_Count, o_Busy, o_Done, o_Tick, o_ClrAck} !== expv()) begin
            n_fail++;
            $display("FAIL random cyc=%0d got=%h exp=%h", k, {o_Count, o_Busy, o_Done, o_Tick, o_ClrAck}, expv());
         end
      end
      i_Hold = 1'b0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_oneshot();
      test_periodic();
      test_hold();
      test_clear();
      test_limits();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
